regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file between two requesters:
  - A is the in-order pipeline writeback.
  - B is the multi-cycle/load completion path.
- Keeps a busy scoreboard of registers reserved by in-flight B operations.
- Flags read-after-write hazards for the decode stage, covering both scoreboarded registers and the write still in flight to the register file.
- Sits between the writeback sources and the register file's Write_EN/dest/Write_Val inputs.

---
 rtl/regfile_write_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for a 32-entry register file: grants one of two writeback
// sources per cycle, tracks busy registers reserved by multi-cycle ops, and flags decode hazards.
module regfile_write_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int RR_ENABLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_valid,
    input  logic [ADDR_W-1:0]      a_dest,
    input  logic [DATA_W-1:0]      a_data,
    output logic                   a_ready,
    input  logic                   b_valid,
    input  logic [ADDR_W-1:0]      b_dest,
    input  logic [DATA_W-1:0]      b_data,
    output logic                   b_ready,
    input  logic                   rsv_valid,
    input  logic [ADDR_W-1:0]      rsv_dest,
    output logic                   rsv_ready,
    input  logic [ADDR_W-1:0]      chk_src1,
    input  logic [ADDR_W-1:0]      chk_src2,
    output logic                   hazard,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_dest,
    output logic [DATA_W-1:0]      wr_val,
    output logic [2**ADDR_W-1:0]   busy_vec
);

    localparam int NREG = 2**ADDR_W;

    logic            grant_a_s;
    logic            grant_b_s;
    logic            conflict_s;
    logic            rr_ptr_r;
    logic            rsv_bypass_s;
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic [NREG-1:0] clr_mask_s;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] one_hot_s;

    assign conflict_s = a_valid & b_valid;

    // Grant selection: rr_ptr_r set means B wins the next conflict.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (conflict_s) begin
            if ((RR_ENABLE != 0) && rr_ptr_r) begin
                grant_b_s = 1'b1;
            end else begin
                grant_a_s = 1'b1;
            end
        end else begin
            grant_a_s = a_valid;
            grant_b_s = b_valid;
        end
    end

    assign a_ready = grant_a_s;
    assign b_ready = grant_b_s;

    // A reservation may land on a register being released by a B grant on the
    // same edge; the new reservation then wins.
    assign rsv_bypass_s = grant_b_s & (b_dest == rsv_dest);
    assign rsv_ready    = rsv_valid & (~busy_r[rsv_dest] | rsv_bypass_s);

    assign one_hot_s  = {{(NREG-1){1'b0}}, 1'b1};
    assign clr_mask_s = grant_b_s ? (one_hot_s << b_dest)   : {NREG{1'b0}};
    assign set_mask_s = rsv_ready ? (one_hot_s << rsv_dest) : {NREG{1'b0}};

    // Next scoreboard value; set after clear so a same-edge reservation survives.
    always_comb begin
        busy_nxt_s    = (busy_r & ~clr_mask_s) | set_mask_s;
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard and round-robin pointer state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r   <= {NREG{1'b0}};
            rr_ptr_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            if (conflict_s) begin
                rr_ptr_r <= grant_a_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Registered register-file write port; writes to r0 are swallowed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_dest <= {ADDR_W{1'b0}};
            wr_val  <= {DATA_W{1'b0}};
        end else if (grant_a_s && (a_dest != {ADDR_W{1'b0}})) begin
            wr_en   <= 1'b1;
            wr_dest <= a_dest;
            wr_val  <= a_data;
        end else if (grant_b_s && (b_dest != {ADDR_W{1'b0}})) begin
            wr_en   <= 1'b1;
            wr_dest <= b_dest;
            wr_val  <= b_data;
        end else begin
            wr_en   <= 1'b0;
            wr_dest <= wr_dest;
            wr_val  <= wr_val;
        end
    end

    assign busy_vec = busy_r;

    assign hazard = (busy_r[chk_src1] && (chk_src1 != {ADDR_W{1'b0}})) ||
                    (busy_r[chk_src2] && (chk_src2 != {ADDR_W{1'b0}})) ||
                    (wr_en && (wr_dest != {ADDR_W{1'b0}}) &&
                     ((wr_dest == chk_src1) || (wr_dest == chk_src2)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter; a second instance
// with RR_ENABLE=0 shares the stimulus to check fixed-priority arbitration.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, rsv_valid;
    logic [4:0]  a_dest, b_dest, rsv_dest, chk_src1, chk_src2;
    logic [31:0] a_data, b_data;

    logic        a_ready, b_ready, rsv_ready, hazard, wr_en;
    logic [4:0]  wr_dest;
    logic [31:0] wr_val, busy_vec;

    logic        a_ready2, b_ready2, rsv_ready2, hazard2, wr_en2;
    logic [4:0]  wr_dest2;
    logic [31:0] wr_val2, busy_vec2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .RR_ENABLE(1)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready),
        .rsv_valid(rsv_valid), .rsv_dest(rsv_dest), .rsv_ready(rsv_ready),
        .chk_src1(chk_src1), .chk_src2(chk_src2), .hazard(hazard),
        .wr_en(wr_en), .wr_dest(wr_dest), .wr_val(wr_val), .busy_vec(busy_vec)
    );

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .RR_ENABLE(0)) dut_fixed (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready2),
        .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready2),
        .rsv_valid(rsv_valid), .rsv_dest(rsv_dest), .rsv_ready(rsv_ready2),
        .chk_src1(chk_src1), .chk_src2(chk_src2), .hazard(hazard2),
        .wr_en(wr_en2), .wr_dest(wr_dest2), .wr_val(wr_val2), .busy_vec(busy_vec2)
    );

    task automatic idle_inputs();
        a_valid = 1'b0; a_dest = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_dest = 5'd0; b_data = 32'd0;
        rsv_valid = 1'b0; rsv_dest = 5'd0;
        chk_src1 = 5'd0; chk_src2 = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #2;
        checks++;
        if (wr_en !== 1'b0 || wr_dest !== 5'd0 || wr_val !== 32'd0 || busy_vec !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got en=%0b dest=%0d val=%0h busy=%0h exp all zero",
                     wr_en, wr_dest, wr_val, busy_vec);
        end
        step();
        step();
        #2 rst = 1'b1;
        step();
    endtask

    task automatic test_a_only();
        a_valid = 1'b1; a_dest = 5'd3; a_data = 32'h11;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++; $display("FAIL a_only_ready got %0b exp 1", a_ready);
        end
        step();
        a_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_dest !== 5'd3 || wr_val !== 32'h11) begin
            errors++;
            $display("FAIL a_only_write got %0b/%0d/%0h exp 1/3/11", wr_en, wr_dest, wr_val);
        end
        step();
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL a_only_idle got wr_en=%0b exp 0", wr_en);
        end
    endtask

    task automatic test_conflict();
        logic       exp_a [3] = '{1'b1, 1'b0, 1'b1};
        logic [4:0] exp_d [3] = '{5'd4, 5'd5, 5'd4};
        logic [31:0] exp_v [3] = '{32'hAA, 32'hBB, 32'hAA};
        a_valid = 1'b1; a_dest = 5'd4; a_data = 32'hAA;
        b_valid = 1'b1; b_dest = 5'd5; b_data = 32'hBB;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (a_ready !== exp_a[i] || b_ready !== !exp_a[i]) begin
                errors++;
                $display("FAIL rr_grant_%0d got a=%0b b=%0b exp a=%0b b=%0b",
                         i, a_ready, b_ready, exp_a[i], !exp_a[i]);
            end
            checks++;
            if (a_ready2 !== 1'b1 || b_ready2 !== 1'b0) begin
                errors++;
                $display("FAIL fixed_grant_%0d got a=%0b b=%0b exp a=1 b=0", i, a_ready2, b_ready2);
            end
            step();
            checks++;
            if (wr_en !== 1'b1 || wr_dest !== exp_d[i] || wr_val !== exp_v[i]) begin
                errors++;
                $display("FAIL rr_write_%0d got %0b/%0d/%0h exp 1/%0d/%0h",
                         i, wr_en, wr_dest, wr_val, exp_d[i], exp_v[i]);
            end
            checks++;
            if (wr_en2 !== 1'b1 || wr_dest2 !== 5'd4 || wr_val2 !== 32'hAA) begin
                errors++;
                $display("FAIL fixed_write_%0d got %0b/%0d/%0h exp 1/4/aa", i, wr_en2, wr_dest2, wr_val2);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_scoreboard();
        rsv_valid = 1'b1; rsv_dest = 5'd7;
        #1;
        checks++;
        if (rsv_ready !== 1'b1) begin
            errors++; $display("FAIL rsv_first got %0b exp 1", rsv_ready);
        end
        step();
        checks++;
        if (busy_vec !== 32'h0000_0080) begin
            errors++; $display("FAIL rsv_busy got %0h exp 80", busy_vec);
        end
        checks++;
        if (rsv_ready !== 1'b0) begin
            errors++; $display("FAIL rsv_again got %0b exp 0", rsv_ready);
        end
        rsv_valid = 1'b0;
        chk_src1 = 5'd7;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++; $display("FAIL hazard_busy got %0b exp 1", hazard);
        end
        b_valid = 1'b1; b_dest = 5'd7; b_data = 32'h77;
        #1;
        checks++;
        if (b_ready !== 1'b1) begin
            errors++; $display("FAIL b_ready_r7 got %0b exp 1", b_ready);
        end
        step();
        b_valid = 1'b0;
        checks++;
        if (busy_vec !== 32'd0 || wr_dest !== 5'd7 || wr_val !== 32'h77 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL b_release got busy=%0h dest=%0d val=%0h hz=%0b exp 0/7/77/1",
                     busy_vec, wr_dest, wr_val, hazard);
        end
        step();
        checks++;
        if (hazard !== 1'b0 || wr_en !== 1'b0) begin
            errors++; $display("FAIL hazard_clear got hz=%0b en=%0b exp 0/0", hazard, wr_en);
        end
        idle_inputs();
    endtask

    task automatic test_r0();
        a_valid = 1'b1; a_dest = 5'd0; a_data = 32'h55;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++; $display("FAIL r0_ready got %0b exp 1", a_ready);
        end
        step();
        a_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL r0_write got wr_en=%0b exp 0", wr_en);
        end
        rsv_valid = 1'b1; rsv_dest = 5'd0;
        #1;
        checks++;
        if (rsv_ready !== 1'b1) begin
            errors++; $display("FAIL r0_rsv_ready got %0b exp 1", rsv_ready);
        end
        step();
        rsv_valid = 1'b0;
        chk_src1 = 5'd0; chk_src2 = 5'd0;
        #1;
        checks++;
        if (busy_vec !== 32'd0 || hazard !== 1'b0) begin
            errors++; $display("FAIL r0_busy got busy=%0h hz=%0b exp 0/0", busy_vec, hazard);
        end
        idle_inputs();
    endtask

    task automatic test_clear_set();
        rsv_valid = 1'b1; rsv_dest = 5'd9;
        step();
        b_valid = 1'b1; b_dest = 5'd9; b_data = 32'h99;
        #1;
        checks++;
        if (b_ready !== 1'b1 || rsv_ready !== 1'b1) begin
            errors++; $display("FAIL clr_set_ready got b=%0b rsv=%0b exp 1/1", b_ready, rsv_ready);
        end
        step();
        idle_inputs();
        checks++;
        if (busy_vec !== 32'h0000_0200 || wr_dest !== 5'd9 || wr_en !== 1'b1) begin
            errors++;
            $display("FAIL clr_set got busy=%0h dest=%0d en=%0b exp 200/9/1", busy_vec, wr_dest, wr_en);
        end
        step();
    endtask

    task automatic test_midop_reset();
        rsv_valid = 1'b1; rsv_dest = 5'd2;
        a_valid = 1'b1; a_dest = 5'd6; a_data = 32'h66;
        step();
        idle_inputs();
        checks++;
        if (wr_en !== 1'b1 || busy_vec[2] !== 1'b1) begin
            errors++; $display("FAIL midop_setup got en=%0b busy2=%0b exp 1/1", wr_en, busy_vec[2]);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || busy_vec !== 32'd0) begin
            errors++; $display("FAIL midop_reset got en=%0b busy=%0h exp 0/0", wr_en, busy_vec);
        end
        step();
        #2 rst = 1'b1;
        step();
        a_valid = 1'b1; a_dest = 5'd4; a_data = 32'hAA;
        b_valid = 1'b1; b_dest = 5'd5; b_data = 32'hBB;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++; $display("FAIL post_reset_rr got a=%0b b=%0b exp 1/0", a_ready, b_ready);
        end
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_conflict();
        test_scoreboard();
        test_r0();
        test_clear_set();
        test_midop_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
